// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and quarter-wave ROM entry generator for the DDS sine source.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dds_pkg;

    localparam int WD_DEF   = 14;
    localparam int PW_DEF   = 32;
    localparam int LAW_DEF  = 8;
    localparam int PIPE_LAT = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dds_state_t;

    // round((2^(wd-1)-1) * sin(pi/2 * (k+0.5)/2^law)), evaluated in Q30 fixed point
    // with a Taylor series so elaboration needs no real-number support.
    function automatic longint qsin_entry(input int k, input int law, input int wd);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint fs;
        x    = (64'sd1686629713 * longint'(2 * k + 1)) >>> (law + 1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        fs = (longint'(1) <<< (wd - 1)) - 1;
        return (fs * sum + (longint'(1) <<< 29)) >>> 30;
    endfunction

endpackage

// File: rtl/dds_sine_gen_qlut.sv
// Registered quarter-wave sine ROM: LAW-bit address in, unsigned magnitude out.
// Latency: 1 clk from addr to mag.
// Backpressure: none; reads every cycle.
module sine_qlut
    import dds_pkg::*;
#(
    parameter int LAW = LAW_DEF,
    parameter int MW  = WD_DEF - 1
) (
    input  logic           clk,
    input  logic [LAW-1:0] addr,
    output logic [MW-1:0]  mag
);

    logic [MW-1:0] rom [2**LAW];

    for (genvar k = 0; k < 2**LAW; k++) begin : g_rom
        localparam longint ENTRY = qsin_entry(k, LAW, MW + 1);
        assign rom[k] = MW'(ENTRY);
    end

    // Synchronous ROM read; entries are half-step offset so none is zero.
    always_ff @(posedge clk) begin
        mag <= rom[addr];
    end

endmodule

// File: rtl/dds_sine_gen.sv
// DDS sine source with programmable frequency, amplitude and burst length.
// Latency: 3 clk from phase accumulator register to sample_out.
// Backpressure: none; free-running sample stream, start ignored while busy.
module dds_sine_gen
    import dds_pkg::*;
#(
    parameter int WD  = WD_DEF,
    parameter int PW  = PW_DEF,
    parameter int LAW = LAW_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 stop,
    input  logic [PW-1:0]        freq_word,
    input  logic [WD-2:0]        amplitude,
    input  logic [15:0]          burst_cycles,
    output logic signed [WD-1:0] sample_out,
    output logic                 sample_valid,
    output logic                 cycle_sync,
    output logic                 busy,
    output logic                 done
);

    localparam int MW = WD - 1;

    dds_state_t    state;
    dds_state_t    state_nxt;
    logic [PW-1:0] acc;
    logic [PW-1:0] inc;
    logic [MW-1:0] amp;
    logic [15:0]   burst;
    logic [15:0]   cycle_cnt;
    logic          stop_pending;
    logic [1:0]    drain_cnt;
    logic          sync0;
    logic [PW:0]   acc_sum;
    logic          wrap;
    logic          burst_end;
    logic          enter_run;
    logic          enter_drain;

    // S1..S3 pipeline
    logic [LAW-1:0]  lut_addr;
    logic [MW-1:0]   mag1;
    logic [MW-1:0]   amp1;
    logic            q1;
    logic            v1;
    logic            s1;
    logic [2*MW-1:0] prod;
    logic [MW-1:0]   scaled2;
    logic            q2;
    logic            v2;
    logic            s2;

    assign acc_sum   = {1'b0, acc} + {1'b0, inc};
    assign wrap      = acc_sum[PW];
    assign burst_end = (burst != 16'd0) && ((cycle_cnt + 16'd1) == burst);
    assign busy      = (state != IDLE);

    // Next-state decode: run until the terminating wrap, then flush the pipeline.
    always_comb begin
        state_nxt   = state;
        enter_run   = 1'b0;
        enter_drain = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if ((wrap && (burst_end || stop_pending || stop)) ||
                    ((stop || stop_pending) && (inc == '0))) begin
                    state_nxt   = DRAIN;
                    enter_drain = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'(PIPE_LAT - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase accumulator, shadow registers (re-latched only at wrap), counters, done pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc          <= '0;
            inc          <= '0;
            amp          <= '0;
            burst        <= '0;
            cycle_cnt    <= '0;
            stop_pending <= 1'b0;
            drain_cnt    <= '0;
            sync0        <= 1'b0;
            done         <= 1'b0;
        end else begin
            sync0 <= 1'b0;
            done  <= (state == DRAIN) && (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    acc <= '0;
                    if (enter_run) begin
                        inc          <= freq_word;
                        amp          <= amplitude;
                        burst        <= burst_cycles;
                        cycle_cnt    <= '0;
                        stop_pending <= 1'b0;
                        sync0        <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_pending <= 1'b1;
                    end
                    if (wrap) begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                        inc       <= freq_word;
                        amp       <= amplitude;
                    end
                    if (enter_drain) begin
                        acc       <= '0;
                        drain_cnt <= '0;
                    end else begin
                        acc   <= acc_sum[PW-1:0];
                        sync0 <= wrap;
                    end
                end
                DRAIN: begin
                    acc       <= '0;
                    drain_cnt <= drain_cnt + 2'd1;
                end
                default: acc <= '0;
            endcase
        end
    end

    // Odd quadrants walk the quarter-wave table backwards.
    assign lut_addr = acc[PW-2] ? ~acc[PW-3 -: LAW] : acc[PW-3 -: LAW];

    sine_qlut #(
        .LAW (LAW),
        .MW  (MW)
    ) u_qlut (
        .clk  (clk),
        .addr (lut_addr),
        .mag  (mag1)
    );

    // S1 sideband: sign, valid, sync and amplitude travel with the table read.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q1   <= 1'b0;
            v1   <= 1'b0;
            s1   <= 1'b0;
            amp1 <= '0;
        end else begin
            q1   <= acc[PW-1];
            v1   <= (state == RUN);
            s1   <= sync0;
            amp1 <= amp;
        end
    end

    assign prod = {{MW{1'b0}}, mag1} * {{MW{1'b0}}, amp1};

    // S2: amplitude scaling.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            scaled2 <= '0;
            q2      <= 1'b0;
            v2      <= 1'b0;
            s2      <= 1'b0;
        end else begin
            scaled2 <= prod[2*MW-1:MW];
            q2      <= q1;
            v2      <= v1;
            s2      <= s1;
        end
    end

    // S3: apply sign for the negative half-wave; outputs forced to 0 when invalid.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            cycle_sync   <= 1'b0;
        end else begin
            if (v2) begin
                sample_out <= q2 ? -$signed({1'b0, scaled2}) : $signed({1'b0, scaled2});
            end else begin
                sample_out <= '0;
            end
            sample_valid <= v2;
            cycle_sync   <= v2 & s2;
        end
    end

endmodule
